// File: rtl/sgpr_pkg.sv
// Shared types and helpers for the GPR checkpoint/rollback sequencer.
// Build option: define SGPR_CKPT_PARITY_EN to append an even-parity bit to
// every shadow-memory word and check it on restore.
package sgpr_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE     = 3'd1,
    RST_REQ  = 3'd2,
    RST_WAIT = 3'd3,
    DONE     = 3'd4
  } ckpt_state_e;

`ifdef SGPR_CKPT_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PARITY_MAX_W = 128;

  function automatic int addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  function automatic int num_words(input bit rv32e);
    return rv32e ? 16 : 32;
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sgpr_ckpt_ctrl.sv
// Checkpoint/rollback sequencer for the flip-flop GPR file.
// Walks x1..x(N-1) saving each register to a shadow memory or writing it back.
// While busy it owns RF read port B and the RF write port and stalls the core.
// Build option: SGPR_CKPT_PARITY_EN adds a parity bit to shadow words and a
// sticky restore parity error on err_o; without it err_o is tied low.
module sgpr_ckpt_ctrl
  import sgpr_pkg::*;
#(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           save_req_i,
  input  logic                           restore_req_i,
  output logic                           busy_o,
  output logic                           halt_o,
  output logic                           done_o,
  output logic                           err_o,
  input  logic [4:0]                     core_raddr_b_i,
  input  logic [4:0]                     core_waddr_i,
  input  logic [DATA_WIDTH-1:0]          core_wdata_i,
  input  logic                           core_we_i,
  output logic [4:0]                     rf_raddr_b_o,
  input  logic [DATA_WIDTH-1:0]          rf_rdata_b_i,
  output logic [4:0]                     rf_waddr_o,
  output logic [DATA_WIDTH-1:0]          rf_wdata_o,
  output logic                           rf_we_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [4:0]                     mem_addr_o,
  output logic [DATA_WIDTH+PAR_BITS-1:0] mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DATA_WIDTH+PAR_BITS-1:0] mem_rdata_i
);

  localparam int             AW       = addr_width(RV32E);
  localparam logic [AW-1:0]  LAST_IDX = AW'(num_words(RV32E) - 1);
  localparam logic [AW-1:0]  FIRST_IDX = AW'(1);

  ckpt_state_e   state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  // Sequencer state and register index; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= FIRST_IDX;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic: requests are only looked at in IDLE, save has priority.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (save_req_i)         state_nxt = SAVE;
        else if (restore_req_i) state_nxt = RST_REQ;
      end
      SAVE: begin
        if (mem_gnt_i) begin
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 idx_nxt   = idx + AW'(1);
        end
      end
      RST_REQ: begin
        if (mem_gnt_i) state_nxt = RST_WAIT;
      end
      RST_WAIT: begin
        if (mem_rvalid_i) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + AW'(1);
            state_nxt = RST_REQ;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = FIRST_IDX;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = FIRST_IDX;
      end
    endcase
  end

  // RF port mux and shadow-memory request; all decoded from the registered
  // state and index so request fields stay stable until the grant arrives.
  always_comb begin
    rf_raddr_b_o = core_raddr_b_i;
    rf_waddr_o   = core_waddr_i;
    rf_wdata_o   = core_wdata_i;
    rf_we_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 5'd0;
    mem_wdata_o  = '0;
    unique case (state)
      IDLE: begin
        rf_we_o = core_we_i;
      end
      SAVE: begin
        rf_raddr_b_o = 5'(idx);
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = 5'(idx);
`ifdef SGPR_CKPT_PARITY_EN
        mem_wdata_o  = {even_parity(PARITY_MAX_W'(rf_rdata_b_i)), rf_rdata_b_i};
`else
        mem_wdata_o  = rf_rdata_b_i;
`endif
      end
      RST_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = 5'(idx);
      end
      RST_WAIT: begin
        rf_waddr_o = 5'(idx);
        rf_wdata_o = mem_rdata_i[DATA_WIDTH-1:0];
        rf_we_o    = mem_rvalid_i;
      end
      default: begin
        rf_we_o = 1'b0;
      end
    endcase
  end

  assign busy_o = (state != IDLE);
  assign halt_o = busy_o;
  assign done_o = (state == DONE);

`ifdef SGPR_CKPT_PARITY_EN
  logic err_q;

  // Sticky restore parity error: cleared by reset or by accepting a new save;
  // the corrupt word is still written to the RF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && save_req_i) begin
      err_q <= 1'b0;
    end else if (state == RST_WAIT && mem_rvalid_i &&
                 even_parity(PARITY_MAX_W'(mem_rdata_i))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
